dnn_accel_system_pll_reset_seq: RTL and testbench

//   Reset/lock sequencer directly downstream of the system PLL. Drives the PLL's
//   rst input and consumes its locked output. Releases the accelerator system

---
 rtl/dnn_accel_system_pll_reset_seq.sv | 152 +++++++++++++++
 tb/tb_dnn_accel_system_pll_reset_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_accel_system_pll_reset_seq.sv
// dnn_accel_system_pll_reset_seq
//   Reset/lock sequencer sitting directly after the system PLL. Pulses the PLL reset,
//   waits for lock, qualifies lock over a stability window and only then releases the
//   accelerator system reset. Retries the PLL on lock timeout and falls back to a full
//   PLL reset on loss of lock or on a software request made while running. Clocked by
//   the PLL reference clock so it keeps running while the PLL output is down.
//
// Ports
//   refclk          in   PLL reference clock
//   rst             in   synchronous active-high reset
//   pll_locked      in   PLL lock indicator, asynchronous (double-flop synchronised)
//   soft_reset_req  in   level request for a full re-sequence, honoured only in RUN
//   pll_rst         out  reset to the PLL, active-high
//   sys_rst         out  accelerator system reset, active-high
//   ready           out  high only in RUN
//   state_o         out  0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   lock_loss_cnt   out  saturating count of lock losses seen in RUN
//   timeout_cnt     out  saturating count of WAIT_LOCK timeouts
module dnn_accel_system_pll_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 100000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             soft_reset_req,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int unsigned MaxAB     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                        : LOCK_TIMEOUT;
    localparam int unsigned MaxCycles = (MaxAB > STABLE_CYCLES) ? MaxAB : STABLE_CYCLES;
    // Counter only ever needs to reach (window - 1), so clog2 of the largest window fits.
    localparam int unsigned CycW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CycW-1:0] PllRstLast  = CycW'(PLL_RST_CYCLES - 1);
    localparam logic [CycW-1:0] TimeoutLast = CycW'(LOCK_TIMEOUT - 1);
    localparam logic [CycW-1:0] StableLast  = CycW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StPllRst   = 2'd0,
        StWaitLock = 2'd1,
        StStable   = 2'd2,
        StRun      = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CycW-1:0]   cyc_q, cyc_d;
    logic              meta_q, meta_d;
    logic              locked_s_q, locked_s_d;
    logic [CNT_W-1:0]  lock_loss_q, lock_loss_d;
    logic [CNT_W-1:0]  timeout_q, timeout_d;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= StPllRst;
            cyc_q       <= '0;
            meta_q      <= 1'b0;
            locked_s_q  <= 1'b0;
            lock_loss_q <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            meta_q      <= meta_d;
            locked_s_q  <= locked_s_d;
            lock_loss_q <= lock_loss_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        meta_d      = pll_locked;
        locked_s_d  = meta_q;
        lock_loss_d = lock_loss_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            StPllRst: begin
                if (cyc_q == PllRstLast) begin
                    state_d = StWaitLock;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StWaitLock: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (locked_s_q) begin
                    state_d = StStable;
                    cyc_d   = '0;
                end else if (cyc_q == TimeoutLast) begin
                    state_d = StPllRst;
                    cyc_d   = '0;
                    if (timeout_q != CntMax) begin
                        timeout_d = timeout_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StStable: begin
                if (!locked_s_q) begin
                    state_d = StWaitLock;
                    cyc_d   = '0;
                end else if (cyc_q == StableLast) begin
                    state_d = StRun;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StRun: begin
                cyc_d = '0;
                // Loss of lock is checked first so a coincident soft request still counts it.
                if (!locked_s_q) begin
                    state_d = StPllRst;
                    if (lock_loss_q != CntMax) begin
                        lock_loss_d = lock_loss_q + 1'b1;
                    end
                end else if (soft_reset_req) begin
                    state_d = StPllRst;
                end
            end
            default: begin
                state_d = StPllRst;
                cyc_d   = '0;
            end
        endcase
    end

    // Outputs are pure state decodes.
    always_comb begin
        pll_rst       = (state_q == StPllRst);
        sys_rst       = (state_q != StRun);
        ready         = (state_q == StRun);
        state_o       = state_q;
        lock_loss_cnt = lock_loss_q;
        timeout_cnt   = timeout_q;
    end

endmodule

// File: tb/tb_dnn_accel_system_pll_reset_seq.sv
module tb_dnn_accel_system_pll_reset_seq;

    localparam int unsigned PRC  = 4;
    localparam int unsigned LT   = 20;
    localparam int unsigned SC   = 8;
    localparam int unsigned CW   = 2;
    localparam int          MAXC = (1 << CW) - 1;

    logic          refclk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          soft_reset_req;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic [1:0]    state_o;
    logic [CW-1:0] lock_loss_cnt;
    logic [CW-1:0] timeout_cnt;

    int total = 0;
    int bad   = 0;

    dnn_accel_system_pll_reset_seq #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .CNT_W         (CW)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .soft_reset_req(soft_reset_req),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .state_o       (state_o),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 refclk = ~refclk;

    // Reference model: phase number plus cycles remaining in the current timed phase,
    // and a two-deep history of sampled lock.
    int m_phase = 0;
    int m_left  = 0;
    int m_loss  = 0;
    int m_tmo   = 0;
    bit m_h1    = 1'b0;
    bit m_h2    = 1'b0;
    bit m_ls;

    always @(posedge refclk) begin
        m_ls = m_h2;
        if (rst) begin
            m_phase = 0;
            m_left  = PRC;
            m_loss  = 0;
            m_tmo   = 0;
            m_h1    = 1'b0;
            m_h2    = 1'b0;
        end else begin
            m_h2 = m_h1;
            m_h1 = pll_locked;
            case (m_phase)
                0: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_phase = 1;
                        m_left  = LT;
                    end
                end
                1: begin
                    if (m_ls) begin
                        m_phase = 2;
                        m_left  = SC;
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_phase = 0;
                            m_left  = PRC;
                            if (m_tmo < MAXC) m_tmo = m_tmo + 1;
                        end
                    end
                end
                2: begin
                    if (!m_ls) begin
                        m_phase = 1;
                        m_left  = LT;
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_phase = 3;
                    end
                end
                default: begin
                    if (!m_ls) begin
                        m_phase = 0;
                        m_left  = PRC;
                        if (m_loss < MAXC) m_loss = m_loss + 1;
                    end else if (soft_reset_req) begin
                        m_phase = 0;
                        m_left  = PRC;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d need %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        chk("state_o", 32'(state_o), m_phase);
        chk("pll_rst", 32'(pll_rst), 32'(m_phase == 0));
        chk("sys_rst", 32'(sys_rst), 32'(m_phase != 3));
        chk("ready", 32'(ready), 32'(m_phase == 3));
        chk("lock_loss_cnt", 32'(lock_loss_cnt), m_loss);
        chk("timeout_cnt", 32'(timeout_cnt), m_tmo);
    endtask

    // Each step: one active edge, then compare on the falling edge; inputs change there too.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            @(negedge refclk);
            cmp_cycle();
        end
    endtask

    task automatic expect_state(input string tag, input int st);
        chk({tag, " dut"}, 32'(state_o), st);
        chk({tag, " model"}, m_phase, st);
    endtask

    task automatic expect_cnt(input string tag, input int loss, input int tmo);
        chk({tag, " loss"}, 32'(lock_loss_cnt), loss);
        chk({tag, " tmo"}, 32'(timeout_cnt), tmo);
    endtask

    int exp_tmo [4] = '{1, 2, 3, 3};

    initial begin
        rst            = 1'b1;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;

        // Power-up
        tick(3);
        expect_state("reset", 0);
        chk("reset pll_rst", 32'(pll_rst), 1);
        chk("reset sys_rst", 32'(sys_rst), 1);
        chk("reset ready", 32'(ready), 0);
        expect_cnt("reset", 0, 0);
        rst = 1'b0;
        tick(3);
        expect_state("pllrst hold", 0);
        tick(1);
        expect_state("pllrst done", 1);
        pll_locked = 1'b1;
        tick(10);
        chk("pre release ready", 32'(ready), 0);
        tick(1);
        chk("release ready", 32'(ready), 1);
        chk("release sys_rst", 32'(sys_rst), 0);
        expect_cnt("powerup", 0, 0);

        // Soft reset from RUN
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        expect_state("soft run exit", 0);
        expect_cnt("soft run", 0, 0);
        tick(12);
        chk("soft re-release early", 32'(ready), 0);
        tick(1);
        chk("soft re-release", 32'(ready), 1);

        // Lock loss in RUN
        pll_locked = 1'b0;
        tick(2);
        expect_state("loss 2nd edge", 3);
        tick(1);
        expect_state("loss 3rd edge", 0);
        chk("loss pll_rst", 32'(pll_rst), 1);
        chk("loss sys_rst", 32'(sys_rst), 1);
        expect_cnt("loss", 1, 0);
        pll_locked = 1'b1;
        tick(12);
        chk("relock early", 32'(ready), 0);
        tick(1);
        chk("relock ready", 32'(ready), 1);

        // No lock: repeated timeouts, soft request ignored in WAIT_LOCK
        pll_locked = 1'b0;
        tick(3);
        expect_cnt("loss2", 2, 0);
        tick(4);
        expect_state("nolock wait", 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                soft_reset_req = 1'b1;
                tick(1);
                soft_reset_req = 1'b0;
                expect_state("soft in wait", 1);
                tick(18);
            end else begin
                tick(19);
            end
            expect_state("pre timeout", 1);
            tick(1);
            expect_state("timeout", 0);
            chk("timeout_cnt", 32'(timeout_cnt), exp_tmo[k]);
            tick(3);
            expect_state("retry pulse", 0);
            tick(1);
            expect_state("retry wait", 1);
        end

        // Back to RUN, then loss and soft request together
        pll_locked = 1'b1;
        tick(10);
        chk("lock after tmo early", 32'(ready), 0);
        tick(1);
        chk("lock after tmo", 32'(ready), 1);
        pll_locked = 1'b0;
        tick(2);
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        expect_state("simul exit", 0);
        expect_cnt("simul", 3, 3);

        // Single-cycle glitch in STABLE
        pll_locked = 1'b1;
        tick(10);
        expect_state("stable cnt5", 2);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        expect_state("glitch wait", 1);
        chk("glitch ready", 32'(ready), 0);
        tick(1);
        expect_state("glitch restable", 2);
        tick(7);
        chk("glitch early", 32'(ready), 0);
        tick(1);
        chk("glitch release", 32'(ready), 1);
        expect_cnt("glitch", 3, 3);

        // Hard reset mid-STABLE
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        tick(8);
        expect_state("stable cnt3", 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_state("midreset", 0);
        chk("midreset pll_rst", 32'(pll_rst), 1);
        chk("midreset sys_rst", 32'(sys_rst), 1);
        expect_cnt("midreset", 0, 0);
        tick(12);
        chk("post reset early", 32'(ready), 0);
        tick(1);
        chk("post reset ready", 32'(ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
